ifetch_unit: RTL and testbench

Parametrised next-generation instruction fetch unit. It contains a direct-mapped I-cache with configurable lines and line length, a configurable 2-bit-counter branch history table (BHT), and a fetch queue that decouples fetch from decode/issue. It sits between the memory controller (line refill port) and the decoder. It redirects on ROB rollback and trains the BHT from committed branches.

---
 rtl/ifetch_unit_pkg.sv | 27 ++
 rtl/ifetch_unit_fetch_queue.sv | 62 ++++++
 rtl/ifetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_ifetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: instruction width,
// RISC-V opcodes that steer prediction, fetch FSM states and the
// J/B immediate extractors used to form predicted targets.
package ifetch_unit_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_B    = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } fetch_state_e;

  // Sign-extended J-type immediate (JAL offset)
  function automatic logic signed [INST_W-1:0] imm_j(input logic [INST_W-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Sign-extended B-type immediate (conditional branch offset)
  function automatic logic signed [INST_W-1:0] imm_b(input logic [INST_W-1:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// Fetch queue: small FIFO with synchronous flush, head shown from registers.
// Ports:
//   clk, rst        clock, async active-low reset
//   flush           drop all entries (wins over push/pop)
//   push, push_data enqueue one entry (caller never pushes into a full queue
//                   unless popping in the same cycle)
//   pop             dequeue head
//   full, valid     occupancy flags
//   head            current head entry
module ifetch_unit_fetch_queue #(
  parameter int unsigned WIDTH = 97,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: direct-mapped I-cache, 2-bit BHT predictor and a
// fetch queue toward decode.
// Ports:
//   clk, rst                       clock, async active-low reset
//   rdy                            global enable, 0 freezes all state
//   rollback, rollback_pc          flush queue and redirect fetch
//   mem_req, mem_addr              line refill request (line aligned)
//   mem_done, mem_data             refill completion pulse and line data
//   out_valid, out_ready           fetch queue head handshake
//   out_inst, out_pc               head instruction and its PC
//   out_pred_taken, out_pred_pc    head prediction
//   bp_upd, bp_pc, bp_taken        committed conditional branch training
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned ICACHE_LINES = 16,
  parameter int unsigned LINE_WORDS   = 16,
  parameter int unsigned BHT_ENTRIES  = 64,
  parameter int unsigned FQ_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         rollback,
  input  logic [ADDR_W-1:0]            rollback_pc,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_done,
  input  logic [LINE_WORDS*INST_W-1:0] mem_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INST_W-1:0]            out_inst,
  output logic [ADDR_W-1:0]            out_pc,
  output logic                         out_pred_taken,
  output logic [ADDR_W-1:0]            out_pred_pc,
  input  logic                         bp_upd,
  input  logic [ADDR_W-1:0]            bp_pc,
  input  logic                         bp_taken
);

  localparam int unsigned WS_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);
  localparam int unsigned LOW_W = WS_W + 2;
  localparam int unsigned TAG_W = ADDR_W - LOW_W - IDX_W;
  localparam int unsigned FQ_W  = INST_W + 2*ADDR_W + 1;

  fetch_state_e state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic              mem_req_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic              fill;

  // Cache arrays; only the valid bits need reset
  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
  logic [INST_W-1:0]       line_data [ICACHE_LINES][LINE_WORDS];
  logic [1:0]              bht       [BHT_ENTRIES];

  // Lookup at the current pc
  logic [WS_W-1:0]   pc_ws;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [BHT_W-1:0]  pc_bht_idx;
  logic [INST_W-1:0] cur_inst;
  logic [1:0]        bht_ctr;
  logic              hit;

  assign pc_ws      = pc[2 +: WS_W];
  assign pc_idx     = pc[LOW_W +: IDX_W];
  assign pc_tag     = pc[LOW_W+IDX_W +: TAG_W];
  assign pc_bht_idx = pc[2 +: BHT_W];
  assign cur_inst   = line_data[pc_idx][pc_ws];
  assign bht_ctr    = bht[pc_bht_idx];
  assign hit        = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);

  // Refill install target comes from the held request address
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic [INST_W-1:0] fill_words [LINE_WORDS];

  assign fill_idx = mem_addr[LOW_W +: IDX_W];
  assign fill_tag = mem_addr[LOW_W+IDX_W +: TAG_W];

  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_fill
    assign fill_words[w] = mem_data[w*INST_W +: INST_W];
  end

  // Only the index bits of the training PC select a counter
  logic [BHT_W-1:0] bp_idx;
  logic             unused_bp_bits;
  assign bp_idx         = bp_pc[2 +: BHT_W];
  assign unused_bp_bits = ^{bp_pc[ADDR_W-1:BHT_W+2], bp_pc[1:0]};

  // Static-plus-BHT prediction on the cached instruction
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_pc;

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc + ADDR_W'(4);
    case (cur_inst[6:0])
      OPCODE_JAL: begin
        pred_taken = 1'b1;
        pred_pc    = pc + ADDR_W'(imm_j(cur_inst));
      end
      OPCODE_B: begin
        if (bht_ctr[1]) begin
          pred_taken = 1'b1;
          pred_pc    = pc + ADDR_W'(imm_b(cur_inst));
        end
      end
      OPCODE_JALR: ; // register-indirect target is unknown here, fall through
      default: ;
    endcase
  end

  // Queue handshake; rollback suppresses the push and flushes
  logic fq_full;
  logic pop;
  logic push;

  assign pop  = out_valid && out_ready;
  assign push = (state == ST_IDLE) && hit && !rollback && (!fq_full || pop);

  ifetch_unit_fetch_queue #(
    .WIDTH (FQ_W),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk       (clk),
    .rst       (rst),
    .flush     (rdy && rollback),
    .push      (rdy && push),
    .push_data ({cur_inst, pc, pred_taken, pred_pc}),
    .pop       (rdy && pop),
    .full      (fq_full),
    .valid     (out_valid),
    .head      ({out_inst, out_pc, out_pred_taken, out_pred_pc})
  );

  // Next-state: refill FSM and pc redirect
  always_comb begin
    state_nx    = state;
    mem_req_nx  = mem_req;
    mem_addr_nx = mem_addr;
    pc_nx       = pc;
    fill        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rollback && !hit) begin
          state_nx    = ST_REFILL;
          mem_req_nx  = 1'b1;
          mem_addr_nx = {pc[ADDR_W-1:LOW_W], LOW_W'(0)};
        end
      end
      ST_REFILL: begin
        // An in-flight refill always completes, even across a rollback
        if (mem_done) begin
          fill       = 1'b1;
          mem_req_nx = 1'b0;
          state_nx   = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (rollback)  pc_nx = rollback_pc;
    else if (push) pc_nx = pred_pc;
  end

  // State, outputs, valid bits and BHT counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      line_valid <= '0;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[BHT_W'(i)] <= 2'b01;
    end else if (rdy) begin
      state    <= state_nx;
      pc       <= pc_nx;
      mem_req  <= mem_req_nx;
      mem_addr <= mem_addr_nx;
      if (fill) line_valid[fill_idx] <= 1'b1;
      // Saturating 2-bit update; same-cycle lookups see the old value
      if (bp_upd) begin
        if (bp_taken && (bht[bp_idx] != 2'b11))
          bht[bp_idx] <= bht[bp_idx] + 2'b01;
        else if (!bp_taken && (bht[bp_idx] != 2'b00))
          bht[bp_idx] <= bht[bp_idx] - 2'b01;
      end
    end
  end

  // Line data and tags, written only on refill completion
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= fill_words;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: cold start, queue fill/drain, JAL/BEQ
// prediction with BHT training and saturation, rollback during refill and
// asynchronous reset during refill. Memory model answers each request
// MEM_LAT cycles after it is first seen.
module tb_ifetch_unit;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_WORDS = 16;
  localparam int          MEM_LAT    = 3;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] JAL_M8     = 32'hFF9F_F06F; // jal x0, -8
  localparam logic [31:0] BEQ_P16    = 32'h0000_0863; // beq x0, x0, +16

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     rdy = 1'b1;
  logic                     rollback = 1'b0;
  logic [ADDR_W-1:0]        rollback_pc = '0;
  logic                     mem_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_done = 1'b0;
  logic [LINE_WORDS*32-1:0] mem_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [31:0]              out_inst;
  logic [ADDR_W-1:0]        out_pc;
  logic                     out_pred_taken;
  logic [ADDR_W-1:0]        out_pred_pc;
  logic                     bp_upd = 1'b0;
  logic [ADDR_W-1:0]        bp_pc = '0;
  logic                     bp_taken = 1'b0;

  logic [31:0] imem [1024];
  logic [31:0] wa;
  int          mem_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .rollback_pc    (rollback_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_done       (mem_done),
    .mem_data       (mem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pred_taken (out_pred_taken),
    .out_pred_pc    (out_pred_pc),
    .bp_upd         (bp_upd),
    .bp_pc          (bp_pc),
    .bp_taken       (bp_taken)
  );

  initial forever #5 clk = ~clk;

  // Memory: count cycles while a request is up, then pulse mem_done
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_done = 1'b0;
        mem_cnt  = 0;
      end else if (mem_done) begin
        if (rdy) mem_done = 1'b0;
      end else if (mem_req) begin
        mem_cnt++;
        if (mem_cnt == MEM_LAT) begin
          mem_cnt = 0;
          for (int w = 0; w < int'(LINE_WORDS); w++) begin
            wa = (mem_addr >> 2) + 32'(w);
            mem_data[w*32 +: 32] = imem[wa[9:0]];
          end
          mem_done = 1'b1;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check(tag, 64'({out_valid, out_pc}), 64'({1'b1, pc}));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
    int n = 0;
    while (!(mem_req && mem_addr == addr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'({mem_req, mem_addr}), 64'({1'b1, addr}));
  endtask

  task automatic train(input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      bp_upd   = 1'b1;
      bp_pc    = 32'h20;
      bp_taken = taken;
      @(negedge clk);
    end
    bp_upd = 1'b0;
  endtask

  // Redirect to the BEQ at 0x20 and check the freshly fetched prediction
  task automatic probe(input string tag, input logic taken, input logic [31:0] ppc);
    rollback    = 1'b1;
    rollback_pc = 32'h20;
    @(negedge clk);
    rollback = 1'b0;
    wait_valid({tag, "_v"}, 20);
    check_head({tag, "_pc"}, 32'h20);
    check({tag, "_pred"}, 64'({out_pred_taken, out_pred_pc}), 64'({taken, ppc}));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = NOP;

    // Cold start and queue fill with consumer stalled
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("cold_req", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h0}));
    check("cold_empty_c1", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("cold_empty_c4", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_head("cold_first", 32'h0);
    repeat (7) @(negedge clk);
    check_head("fq_hold", 32'h0);

    // Drain: one pc per cycle, 0x10 arrives without a bubble
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_head($sformatf("drain_%0d", k), 32'(4*k));
      @(negedge clk);
    end

    // Rollback while line 0x40 is being refilled
    wait_req("rb_req40", 32'h40, 40);
    rollback    = 1'b1;
    rollback_pc = 32'h400;
    @(negedge clk);
    rollback = 1'b0;
    check("rb_flush", 64'(out_valid), 64'd0);
    check("rb_refill_kept", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h40}));
    wait_req("rb_req400", 32'h400, 20);
    wait_valid("rb_valid", 20);
    check_head("rb_first", 32'h400);

    // Line 0x40 was installed: redirect there hits with no request
    rollback    = 1'b1;
    rollback_pc = 32'h40;
    @(negedge clk);
    rollback = 1'b0;
    check("hit40_noreq_a", 64'(mem_req), 64'd0);
    @(negedge clk);
    check_head("hit40_head", 32'h40);
    check("hit40_noreq_b", 64'(mem_req), 64'd0);

    // JAL prediction and BHT-driven BEQ prediction
    imem[2] = JAL_M8;
    imem[8] = BEQ_P16;
    do_reset();
    wait_valid("b_valid", 20);
    check_head("b_pc0", 32'h0);
    check("b_pred0", 64'({out_pred_taken, out_pred_pc}), 64'({1'b0, 32'h4}));
    @(negedge clk);
    check_head("b_pc4", 32'h4);
    @(negedge clk);
    check_head("b_jal_pc", 32'h8);
    check("b_jal_inst", 64'(out_inst), 64'(JAL_M8));
    check("b_jal_pred", 64'({out_pred_taken, out_pred_pc}), 64'({1'b1, 32'h0}));
    @(negedge clk);
    check_head("b_jal_loop", 32'h0);

    probe("beq_c1", 1'b0, 32'h24);
    train(1'b1, 2);
    probe("beq_c3", 1'b1, 32'h30);
    train(1'b1, 5);
    train(1'b0, 1);
    probe("sat_hi", 1'b1, 32'h30);
    train(1'b0, 5);
    probe("sat_lo", 1'b0, 32'h24);
    train(1'b1, 1);
    probe("no_wrap", 1'b0, 32'h24);

    // Asynchronous reset during a refill with entries queued
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    rollback    = 1'b1;
    rollback_pc = 32'h34;
    @(negedge clk);
    rollback = 1'b0;
    wait_req("c_req40", 32'h40, 30);
    check_head("c_held", 32'h34);
    #3 rst = 1'b0;
    #1;
    check("async_req", 64'(mem_req), 64'd0);
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("restart_req", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h0}));
    wait_valid("restart_valid", 20);
    check_head("restart_first", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
